// File: rtl/addr_seq_pkg.sv
// Shared types and helpers for the multi-channel address sequencer/arbiter.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int DEF_NUM_CH = 3;
    localparam int NUM_REQ    = 2 * DEF_NUM_CH;
    localparam int MAX_CNT_W  = 32;

    // Reverses the low log2n bits of val; bits at or above log2n (or cnt_w) come back as 0.
    function automatic logic [MAX_CNT_W-1:0] bit_reverse(input logic [MAX_CNT_W-1:0] val,
                                                        input int                   cnt_w,
                                                        input logic [4:0]           log2n);
        logic [MAX_CNT_W-1:0] res;
        logic [4:0]           src;
        res = '0;
        for (int i = 0; i < MAX_CNT_W; i++) begin
            if (i < cnt_w && i < int'(log2n)) begin
                src    = log2n - 5'd1 - 5'(i);
                res[i] = val[src];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/addr_seq_counter.sv
// One requestor: IDLE/RUN/DONE sequencing, sample counter and registered done flag.
module addr_seq_counter
    import addr_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             req_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] filesize_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o,
    output logic             eligible_o
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
                ST_RUN: begin
                    if (cnt_q == filesize_i) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (inc_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Gated by enable so a channel being switched off cannot win one last grant.
    assign eligible_o = enable_i && (state_q == ST_RUN) && req_i && (cnt_q < filesize_i);
    assign count_o    = cnt_q;
    assign done_o     = done_q;

endmodule

// File: rtl/addr_seq_arbiter.sv
// NUM_CH channels of read/write address sequencers sharing one registered address port.
module addr_seq_arbiter
    import addr_seq_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          offset,
    input  logic [CNT_W-1:0]           filesize,
    input  logic [4:0]                 log2n,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [NUM_CH-1:0]          ch_bitrev,
    input  logic [NUM_CH-1:0]          rd_req,
    input  logic [NUM_CH-1:0]          wr_req,
    input  logic                       addr_ready,
    output logic                       addr_valid,
    output logic [ADDR_W-1:0]          addr,
    output logic [$clog2(NUM_CH)-1:0]  addr_ch,
    output logic                       addr_is_wr,
    output logic [NUM_CH-1:0]          rd_done,
    output logic [NUM_CH-1:0]          wr_done
);

    localparam int NREQ = 2 * NUM_CH;
    localparam int RW   = $clog2(NREQ);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NREQ-1:0]   en_vec, req_vec, elig, inc, done;
    logic [CNT_W-1:0]  cnt [NREQ];
    logic [RW-1:0]     rr_q, rr_d, gnt_idx, cand;
    logic              gnt_vld, load, gnt_wr;
    logic [CH_W-1:0]   gnt_ch, ch_q;
    logic [CNT_W-1:0]  gnt_cnt, idx;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              valid_q, wr_q;

    // Requestor r = 2*ch + is_wr.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            en_vec[2*c]    = ch_enable[c];
            en_vec[2*c+1]  = ch_enable[c];
            req_vec[2*c]   = rd_req[c];
            req_vec[2*c+1] = wr_req[c];
            rd_done[c]     = done[2*c];
            wr_done[c]     = done[2*c+1];
        end
    end

    for (genvar r = 0; r < NREQ; r++) begin : g_seq
        addr_seq_counter #(.CNT_W(CNT_W)) u_seq (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable_i   (en_vec[r]),
            .req_i      (req_vec[r]),
            .inc_i      (inc[r]),
            .filesize_i (filesize),
            .count_o    (cnt[r]),
            .done_o     (done[r]),
            .eligible_o (elig[r])
        );
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = RW'((int'(rr_q) + k) % NREQ);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign load = !valid_q || addr_ready;
    assign rr_d = (gnt_idx == RW'(NREQ - 1)) ? '0 : gnt_idx + RW'(1);

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            inc[r] = load && gnt_vld && (gnt_idx == RW'(r));
        end
    end

    assign gnt_ch  = CH_W'(gnt_idx >> 1);
    assign gnt_wr  = gnt_idx[0];
    assign gnt_cnt = cnt[gnt_idx];

    // Only reads are reordered; writes always land in linear order.
    always_comb begin
        idx = gnt_cnt;
        if (!gnt_wr && ch_bitrev[gnt_ch]) begin
            idx = CNT_W'(bit_reverse(MAX_CNT_W'(gnt_cnt), CNT_W, log2n));
        end
    end

    assign addr_d = offset + ADDR_W'(idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            ch_q    <= '0;
            wr_q    <= 1'b0;
            rr_q    <= '0;
        end else if (load) begin
            valid_q <= gnt_vld;
            if (gnt_vld) begin
                addr_q <= addr_d;
                ch_q   <= gnt_ch;
                wr_q   <= gnt_wr;
                rr_q   <= rr_d;
            end
        end
    end

    assign addr_valid = valid_q;
    assign addr       = addr_q;
    assign addr_ch    = ch_q;
    assign addr_is_wr = wr_q;

endmodule

// File: tb/tb_addr_seq_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_addr_seq_arbiter;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int NREQ   = 2 * NUM_CH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] offset = '0;
    logic [CNT_W-1:0]  filesize = '0;
    logic [4:0]        log2n = 5'd1;
    logic [NUM_CH-1:0] ch_enable = '0, ch_bitrev = '0, rd_req = '0, wr_req = '0;
    logic              addr_ready = 1'b1;
    logic              addr_valid, addr_is_wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        addr_ch;
    logic [NUM_CH-1:0] rd_done, wr_done;

    int n_checks = 0;
    int n_pass   = 0;

    addr_seq_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .offset(offset), .filesize(filesize), .log2n(log2n),
        .ch_enable(ch_enable), .ch_bitrev(ch_bitrev), .rd_req(rd_req), .wr_req(wr_req),
        .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr), .addr_ch(addr_ch),
        .addr_is_wr(addr_is_wr), .rd_done(rd_done), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference model: per-requestor phase (0 waiting, 1 issuing, 2 finished) and issued count.
    bit          m_valid;
    logic [31:0] m_addr;
    int          m_ch, m_wr, m_rr;
    int          m_phase [NREQ];
    int          m_cnt   [NREQ];
    bit          m_done  [NREQ];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_enable  = '0;
        rd_req     = '0;
        wr_req     = '0;
        ch_bitrev  = '0;
        addr_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit m_wants(int r);
        bit rq;
        rq = (r % 2 == 1) ? wr_req[r/2] : rd_req[r/2];
        return ch_enable[r/2] && m_phase[r] == 1 && rq && m_cnt[r] < int'(filesize);
    endfunction

    function automatic logic [31:0] m_index(int r);
        int v, rev;
        if (r % 2 == 0 && ch_bitrev[r/2]) begin
            v   = m_cnt[r];
            rev = 0;
            repeat (int'(log2n)) begin
                rev = (rev << 1) | (v & 1);
                v   = v >> 1;
            end
            return 32'(rev);
        end
        return 32'(m_cnt[r]);
    endfunction

    function automatic void model_tick();
        int g;
        g = -1;
        if (!m_valid || addr_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = (m_rr + k) % NREQ;
                if (g < 0 && m_wants(r)) g = r;
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_ch   = g / 2;
                m_wr   = g % 2;
                m_addr = offset + m_index(g);
                m_rr   = (g + 1) % NREQ;
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (!ch_enable[r/2]) begin
                m_phase[r] = 0; m_cnt[r] = 0; m_done[r] = 0;
            end else if (m_phase[r] == 0) begin
                m_phase[r] = 1; m_cnt[r] = 0;
            end else if (m_phase[r] == 1) begin
                if (m_cnt[r] == int'(filesize)) begin
                    m_phase[r] = 2; m_done[r] = 1;
                end else if (r == g) begin
                    m_cnt[r]++;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        n_checks++;
        if (addr_valid !== 1'b0 || addr !== '0 || addr_ch !== '0 || addr_is_wr !== 1'b0)
            $display("FAIL reset_outputs valid=%b addr=%h ch=%0d wr=%b want all 0", addr_valid, addr, addr_ch, addr_is_wr);
        else n_pass++;
        n_checks++;
        if (rd_done !== '0 || wr_done !== '0)
            $display("FAIL reset_done rd=%b wr=%b want 000/000", rd_done, wr_done);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        n_checks++;
        if (addr_valid !== 1'b0)
            $display("FAIL reset_idle valid=%b want 0", addr_valid);
        else n_pass++;
    endtask

    task automatic test_linear();
        do_reset();
        offset = 32'h1000; filesize = 16'd4; log2n = 5'd2;
        ch_enable = 3'b001; rd_req = 3'b001;
        tick();
        n_checks++;
        if (addr_valid !== 1'b0) $display("FAIL linear_first valid=%b want 0", addr_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== 32'h1000 + i || addr_ch !== 2'd0 || addr_is_wr !== 1'b0 || rd_done !== 3'b000)
                $display("FAIL linear[%0d] valid=%b addr=%h ch=%0d wr=%b rd_done=%b want 1 %h 0 0 000",
                         i, addr_valid, addr, addr_ch, addr_is_wr, rd_done, 32'h1000 + i);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b001 || wr_done !== 3'b000)
            $display("FAIL linear_done valid=%b rd=%b wr=%b want 0 001 000", addr_valid, rd_done, wr_done);
        else n_pass++;
        ch_enable = '0; rd_req = '0;
        tick();
        n_checks++;
        if (rd_done !== 3'b000) $display("FAIL linear_clear rd=%b want 000", rd_done);
        else n_pass++;
    endtask

    task automatic test_bitrev();
        int exp_idx [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        do_reset();
        offset = 32'h1000; filesize = 16'd8; log2n = 5'd3;
        ch_enable = 3'b001; rd_req = 3'b001; ch_bitrev = 3'b001;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== 32'h1000 + exp_idx[i] || addr_is_wr !== 1'b0)
                $display("FAIL bitrev[%0d] valid=%b addr=%h wr=%b want 1 %h 0",
                         i, addr_valid, addr, addr_is_wr, 32'h1000 + exp_idx[i]);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b001)
            $display("FAIL bitrev_done valid=%b rd=%b want 0 001", addr_valid, rd_done);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        offset = 32'h1000; filesize = 16'd2;
        ch_enable = 3'b111; rd_req = 3'b111; wr_req = 3'b111;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== 32'h1000 + i / 6 || addr_ch !== 2'((i % 6) / 2) || addr_is_wr !== 1'((i % 6) % 2))
                $display("FAIL rr[%0d] valid=%b addr=%h ch=%0d wr=%b want 1 %h %0d %0d",
                         i, addr_valid, addr, addr_ch, addr_is_wr, 32'h1000 + i / 6, (i % 6) / 2, i % 2);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b111 || wr_done !== 3'b111)
            $display("FAIL rr_done valid=%b rd=%b wr=%b want 0 111 111", addr_valid, rd_done, wr_done);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        offset = 32'h1000; filesize = 16'd4;
        ch_enable = 3'b001; rd_req = 3'b001;
        tick(); tick();
        tick();
        n_checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h1001) $display("FAIL stall_pre valid=%b addr=%h want 1 00001001", addr_valid, addr);
        else n_pass++;
        addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== 32'h1001 || addr_ch !== 2'd0 || addr_is_wr !== 1'b0)
                $display("FAIL stall_hold[%0d] valid=%b addr=%h ch=%0d wr=%b want 1 00001001 0 0", i, addr_valid, addr, addr_ch, addr_is_wr);
            else n_pass++;
        end
        addr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== 32'h1002 + i)
                $display("FAIL stall_resume[%0d] valid=%b addr=%h want 1 %h", i, addr_valid, addr, 32'h1002 + i);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b001) $display("FAIL stall_done valid=%b rd=%b want 0 001", addr_valid, rd_done);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_filesize_zero();
        do_reset();
        offset = 32'h1000; filesize = 16'd0;
        ch_enable = 3'b010; rd_req = 3'b010; wr_req = 3'b010;
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b000 || wr_done !== 3'b000)
            $display("FAIL fs0_early valid=%b rd=%b wr=%b want 0 000 000", addr_valid, rd_done, wr_done);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (addr_valid !== 1'b0 || rd_done !== 3'b010 || wr_done !== 3'b010)
                $display("FAIL fs0_done[%0d] valid=%b rd=%b wr=%b want 0 010 010", i, addr_valid, rd_done, wr_done);
            else n_pass++;
        end
        ch_enable = '0;
        tick();
        n_checks++;
        if (addr_valid !== 1'b0 || rd_done !== 3'b000 || wr_done !== 3'b000)
            $display("FAIL fs0_clear valid=%b rd=%b wr=%b want 0 000 000", addr_valid, rd_done, wr_done);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        offset = 32'h1000; filesize = 16'd4;
        ch_enable = 3'b001; rd_req = 3'b001;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (addr_valid !== 1'b0 || addr !== '0 || addr_ch !== '0 || addr_is_wr !== 1'b0 || rd_done !== '0 || wr_done !== '0)
            $display("FAIL midreset_outputs valid=%b addr=%h ch=%0d wr=%b rd=%b wr=%b want all 0",
                     addr_valid, addr, addr_ch, addr_is_wr, rd_done, wr_done);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        n_checks++;
        if (addr_valid !== 1'b0) $display("FAIL midreset_rearm valid=%b want 0", addr_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h1000) $display("FAIL midreset_restart valid=%b addr=%h want 1 00001000", addr_valid, addr);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_random(input logic [31:0] base, input int cycles);
        logic [NUM_CH-1:0] exp_rd, exp_wr;
        do_reset();
        m_valid = 0; m_addr = '0; m_ch = 0; m_wr = 0; m_rr = 0;
        for (int r = 0; r < NREQ; r++) begin m_phase[r] = 0; m_cnt[r] = 0; m_done[r] = 0; end
        offset    = base;
        filesize  = 16'($urandom_range(0, 7));
        log2n     = 5'($urandom_range(1, 3));
        ch_bitrev = 3'($urandom);
        for (int n = 0; n < cycles; n++) begin
            for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 15) == 0) ch_enable[c] = ~ch_enable[c];
            rd_req     = 3'($urandom);
            wr_req     = 3'($urandom);
            addr_ready = ($urandom_range(0, 3) != 0);
            model_tick();
            tick();
            for (int c = 0; c < NUM_CH; c++) begin exp_rd[c] = m_done[2*c]; exp_wr[c] = m_done[2*c+1]; end
            n_checks++;
            if (addr_valid !== m_valid) $display("FAIL rand_valid[%0d] got %b want %b", n, addr_valid, m_valid);
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if (addr !== m_addr || addr_ch !== 2'(m_ch) || addr_is_wr !== 1'(m_wr))
                    $display("FAIL rand_addr[%0d] got %h ch=%0d wr=%b want %h ch=%0d wr=%0d", n, addr, addr_ch, addr_is_wr, m_addr, m_ch, m_wr);
                else n_pass++;
            end
            n_checks++;
            if (rd_done !== exp_rd || wr_done !== exp_wr)
                $display("FAIL rand_done[%0d] rd=%b wr=%b want %b %b", n, rd_done, wr_done, exp_rd, exp_wr);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_linear();
        test_bitrev();
        test_round_robin();
        test_stall();
        test_filesize_zero();
        test_reset_mid();
        test_random(32'hFFFF_FFFC, 400);
        test_random($urandom, 400);
        test_random(32'h0000_2000, 400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_seq_arbiter.md
Name: addr_seq_arbiter

Overview:
- Parametrised successor to the fixed three-engine (FFT/FIR/IIR) address calculator top.
- Holds NUM_CH channels, each with an independent read sequencer and write sequencer (2*NUM_CH requestors in total).
- A round-robin arbiter chooses one requestor per cycle and drives a single registered address port with a valid/ready handshake.
- Per-channel bit-reversed read ordering supports FFT engines; linear ordering serves filter engines.

Parameters:
- NUM_CH, 3, number of engine channels.
- ADDR_W, 32, address width.
- CNT_W, 16, sample-index width; filesize is at most 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- offset  in  ADDR_W  base address, shared by all channels.
- filesize  in  CNT_W  number of samples per pass, shared.
- log2n  in  5  FFT size exponent for bit reversal; valid range 1..CNT_W.
- ch_enable  in  NUM_CH  per-channel run enable (level).
- ch_bitrev  in  NUM_CH  1 = read index is bit-reversed for that channel.
- rd_req  in  NUM_CH  read address request (level; deasserting it pauses the channel).
- wr_req  in  NUM_CH  write address request (level).
- addr_ready  in  1  memory accepts the current address.
- addr_valid  out  1  addr / addr_ch / addr_is_wr are valid.
- addr  out  ADDR_W  generated address.
- addr_ch  out  $clog2(NUM_CH)  channel owning addr.
- addr_is_wr  out  1  1 = write address, 0 = read address.
- rd_done  out  NUM_CH  read pass complete (level).
- wr_done  out  NUM_CH  write pass complete (level).

Behaviour:
- Reset: addr_valid, addr, addr_ch, addr_is_wr, rd_done, wr_done, all counters and the round-robin pointer are 0. All requestors go to IDLE.
- Requestor index: r = 2*ch + is_wr. Each requestor runs its own state machine: IDLE, RUN, DONE.
  - IDLE -> RUN when ch_enable[ch] is high; counter is 0.
  - RUN -> DONE on the cycle its counter reaches filesize. The done bit is registered and rises the following cycle.
  - DONE holds until ch_enable[ch] falls, then returns to IDLE.
  - ch_enable low in any state forces IDLE and clears the counter and done bit on the next edge.
- Eligibility: requestor is in RUN, its req bit is high, and count < filesize.
- Output stage loads when (!addr_valid || addr_ready).
  - On load, the arbiter grants the first eligible requestor at or after rr_ptr, in cyclic order. rr_ptr then becomes grant+1 mod 2*NUM_CH.
  - The granted counter increments on the same edge.
  - If no requestor is eligible, addr_valid goes to 0.
- Stall: while addr_valid && !addr_ready, addr, addr_ch and addr_is_wr are held stable. No counter advances and rr_ptr is frozen.
- Address arithmetic:
  - addr = offset + zero-extended idx, truncated to ADDR_W (wraps silently).
  - idx = count for writes, and for reads with ch_bitrev=0.
  - For reads with ch_bitrev=1: idx = bit-reverse of count[log2n-1:0]; upper bits of idx are 0.
- Latency: one cycle from an eligible request (with the output stage free) to addr_valid.
- Back-to-back: with addr_ready held high, one address per cycle.
- filesize = 0: the requestor goes RUN -> DONE without issuing any address; done rises 2 cycles after enable.
- Enable dropped while that channel's address sits in the output stage: the address still completes its handshake. The counter is cleared regardless.
- rd_req/wr_req deasserted mid-pass: the counter holds (pause); no re-arm is needed.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous); any in-flight address is dropped.
- offset, filesize and log2n must be stable while any channel is enabled. Behaviour is undefined if they change in that window.

Decomposition:
- Package addr_seq_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam NUM_REQ = 2*NUM_CH;
  - a bit-reverse function parameterised by CNT_W and log2n.
- Sub-module addr_seq_counter, instantiated once per requestor. It contains the state machine, counter, done register and eligible output. Inputs are enable, req, inc and filesize.
- The top module holds the round-robin arbiter, index/bit-reverse muxing, adder and output register.

Test Plan:
- NUM_CH=3, offset=0x1000, filesize=4; ch0 enabled with rd_req high, addr_ready=1 -> addr 0x1000, 0x1001, 0x1002, 0x1003 on consecutive cycles; rd_done[0] high on the cycle after the last address; addr_valid then 0.
- ch0 with ch_bitrev=1, log2n=3, filesize=8, read -> idx sequence 0,4,2,6,1,5,3,7; addresses are offset plus each idx.
- All 6 requestors eligible, filesize=2 -> grant order r0..r5, then r0..r5 again; addr_ch/addr_is_wr pairs follow (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); all done bits high at the end.
- addr_ready held low for 3 cycles with addr=0x1001 pending -> addr unchanged for 3 cycles; ch0 read counter unchanged; next address is 0x1002 after ready returns.
- ch1 enabled with filesize=0 -> no addr_valid from ch1; rd_done[1] and wr_done[1] high 2 cycles after enable; both clear one cycle after ch_enable[1] falls.
- rst_n pulsed low mid-pass (count=2) -> all outputs 0 immediately; after release with ch_enable still high, the pass restarts at offset+0.
